pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard controller driving the D->E pipeline register and its neighbours. Reads the E-stage
//  fields that register produces (Rs1E/Rs2E/RdE/ResultSrcE) plus M/W destinations. Generates:
//  - forwarding selects, load-use stall, branch flush (CLR_E);
//  - a data-memory wait handshake with timeout FSM and saturating stall/flush counters.
// PARAMETERS
//  WAIT_TIMEOUT 16  max consecutive dmem wait cycles before FAULT (>=1)
//  CNT_W        16  width of performance counters
// PORTS
//  clk         in  1      rising-edge clock
//  rst         in  1      synchronous active-high reset
//  Rs1D,Rs2D   in  5      D-stage source regs
//  Rs1E,Rs2E   in  5      E-stage source regs
//  RdE         in  5      E-stage destination
//  ResultSrcE  in  2      E-stage result select; 2'b01 = load
//  PCSrcE      in  1      taken branch/jump resolved in E
//  RdM,RdW     in  5      M/W destinations
//  RegWriteM   in  1      M writes RF
//  RegWriteW   in  1      W writes RF
//  dmem_req_M  in  1      M-stage load/store active
//  dmem_ready  in  1      data memory completes access this cycle
//  ForwardAE   out 2      00 RD1_E, 10 ALUResultM, 01 ResultW
//  ForwardBE   out 2      same encoding for RD2_E
//  StallF      out 1      hold PC
//  StallD      out 1      hold F/D reg
//  StallE      out 1      hold D/E reg
//  StallM      out 1      hold E/M reg
//  FlushD      out 1      clear F/D reg
//  CLR_E       out 1      clear D/E reg
//  fault       out 1      sticky dmem timeout flag
//  stall_cnt   out CNT_W  cycles with any stall asserted
//  flush_cnt   out CNT_W  cycles with CLR_E asserted
// BEHAVIOUR
//  - Reset (rst=1, sync): state=RUN, wait_cnt=0, counters=0, fault=0.
//  - Reset outputs: ForwardAE/BE=00, all Stall*=0, FlushD=CLR_E=1; pipeline clears that edge.
//  - Forwarding is combinational, same cycle. ForwardAE=10 if RegWriteM&&RdM!=0&&RdM==Rs1E.
//    Else 01 if RegWriteW&&RdW!=0&&RdW==Rs1E, else 00; M beats W. ForwardBE likewise on Rs2E.
//  - lw_stall = ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
//  - mem_wait = dmem_req_M && !dmem_ready.
//  - FSM states: RUN, WAIT, FAULT.
//    RUN->WAIT when mem_wait; wait_cnt<=1.
//    WAIT->RUN when dmem_ready; wait_cnt<=0.
//    WAIT->FAULT when mem_wait && wait_cnt==WAIT_TIMEOUT; else wait_cnt++.
//    FAULT exits only via rst.
//  - RUN or WAIT with mem_wait=1: StallF=StallD=StallE=StallM=1, FlushD=CLR_E=0.
//    lw_stall and PCSrcE are ignored (held in place). Stall is asserted in the first cycle
//    mem_wait rises, before the state register updates.
//  - No mem_wait, PCSrcE=1: FlushD=1, CLR_E=1, no stalls. If lw_stall is also set (illegal), PCSrcE wins.
//  - No mem_wait, lw_stall=1, PCSrcE=0: StallF=StallD=1, CLR_E=1 (bubble), StallE=StallM=0.
//  - FAULT: all Stall*=1, FlushD=CLR_E=0, fault=1; forwarding still combinational.
//  - Counters saturate at 2^CNT_W-1 (no wrap).
//    stall_cnt +1 per cycle any Stall* is 1; flush_cnt +1 per cycle CLR_E is 1.
//    Neither counts while rst=1.
//  - Reset mid-WAIT: returns to RUN next cycle regardless of dmem_ready.
// TESTING
//  - Fwd: RegWriteM=1,RdM=5,Rs1E=5; RegWriteW=1,RdW=5 -> ForwardAE=10.
//    RdM=0 -> ForwardAE=01; RegWriteW=0 -> 00.
//  - Load-use: ResultSrcE=01,RdE=7,Rs2D=7 -> StallF=StallD=CLR_E=1 one cycle; stall_cnt=1, flush_cnt=1.
//  - Branch: PCSrcE=1 with lw_stall=1 -> FlushD=CLR_E=1, StallF=0.
//  - Mem wait: dmem_req_M=1, ready low 3 cycles -> 4 stalls high 3 cycles; back to RUN on ready; stall_cnt=3.
//  - Timeout: WAIT_TIMEOUT=4, ready never -> FAULT, fault=1, stalls held.
//    rst 1 cycle -> RUN, fault=0, counters 0.
//  - Saturation: CNT_W=4, 20 lw_stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline: operand forwarding, load-use bubbles, branch
// flushes, and a data-memory wait handshake that latches a fault after too many wait cycles.
module pipeline_hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             dmem_req_M,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             CLR_E,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WC_W-1:0]  WAIT_LIMIT = WC_W'(WAIT_TIMEOUT);
  localparam logic [WC_W-1:0]  WC_ONE     = WC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              lw_stall;
  logic              mem_wait;
  logic              stall_any;
  logic [4:0]        rs_e    [2];
  logic [1:0]        fwd_sel [2];

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_wait = dmem_req_M && !dmem_ready;

  // Forwarding: the M-stage result is newer than W, so it takes priority.
  assign rs_e[0] = Rs1E;
  assign rs_e[1] = Rs2E;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] = rst ? 2'b00 :
                           (RegWriteM && (RdM != 5'd0) && (RdM == rs_e[gi])) ? 2'b10 :
                           (RegWriteW && (RdW != 5'd0) && (RdW == rs_e[gi])) ? 2'b01 :
                           2'b00;
    end
  endgenerate

  assign ForwardAE = fwd_sel[0];
  assign ForwardBE = fwd_sel[1];

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    CLR_E  = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      CLR_E  = 1'b1;
    end else if ((state_q == ST_FAULT) || mem_wait) begin
      // Freeze the whole pipeline; pending branch or load-use action waits for memory.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      CLR_E  = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      CLR_E  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WC_ONE;
        end
      end
      ST_WAIT: begin
        // Leaving on !mem_wait also covers a request that is withdrawn without ready.
        if (!mem_wait) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d = ST_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_ONE;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign stall_any = StallF | StallD | StallE | StallM;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_any && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (CLR_E && (flush_cnt_q != CNT_MAX))     flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fault     = (state_q == ST_FAULT);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a vector table, directed multi-cycle sequences and random
// traffic, all checked against a rule-level model of the controller.
module tb_pipeline_hazard_ctrl;

  localparam int WT   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] rsrc;
    logic       pcsrc;
    logic [4:0] rdm, rdw;
    logic       rwm, rww, req, rdy;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [1:0] fa, fb;
    logic [3:0] st;   // {StallF, StallD, StallE, StallM}
    logic       fd, clr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, PCSrcE, RegWriteM, RegWriteW, dmem_req_M, dmem_ready;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE, ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, FlushD, CLR_E, fault;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .CLR_E(CLR_E), .fault(fault),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_err = 0;
  int n_checks = 0;

  // Model state: sticky fault, length of the current run of wait cycles, counters.
  bit m_fault;
  int m_run, m_scnt, m_fcnt;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input in_t v);
    if (v.rst) return 2'b00;
    if (v.rwm && v.rdm != 0 && v.rdm == rs) return 2'b10;
    if (v.rww && v.rdw != 0 && v.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step(input in_t v, input bit use_tbl, input vec_t t, input string tag);
    logic [1:0] efa, efb;
    logic [3:0] est, ast;
    logic       efd, ecl;
    bit         mw, lw;
    rst = v.rst; Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
    ResultSrcE = v.rsrc; PCSrcE = v.pcsrc; RdM = v.rdm; RdW = v.rdw; RegWriteM = v.rwm;
    RegWriteW = v.rww; dmem_req_M = v.req; dmem_ready = v.rdy;
    #3;
    mw  = v.req && !v.rdy;
    lw  = (v.rsrc == 2'b01) && (v.rde != 0) && (v.rde == v.rs1d || v.rde == v.rs2d);
    efa = exp_fwd(v.rs1e, v);
    efb = exp_fwd(v.rs2e, v);
    est = 4'h0; efd = 1'b0; ecl = 1'b0;
    if (v.rst) begin efd = 1'b1; ecl = 1'b1; end
    else if (m_fault || mw) est = 4'hF;
    else if (v.pcsrc) begin efd = 1'b1; ecl = 1'b1; end
    else if (lw) begin est = 4'b1100; ecl = 1'b1; end
    ast = {StallF, StallD, StallE, StallM};
    chk({tag, " ForwardAE"}, 32'(ForwardAE), 32'(efa));
    chk({tag, " ForwardBE"}, 32'(ForwardBE), 32'(efb));
    chk({tag, " stalls"},    32'(ast),       32'(est));
    chk({tag, " FlushD"},    32'(FlushD),    32'(efd));
    chk({tag, " CLR_E"},     32'(CLR_E),     32'(ecl));
    chk({tag, " fault"},     32'(fault),     32'(m_fault));
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(m_scnt));
    chk({tag, " flush_cnt"}, 32'(flush_cnt), 32'(m_fcnt));
    if (use_tbl) begin
      chk({tag, " tbl ForwardAE"}, 32'(ForwardAE), 32'(t.fa));
      chk({tag, " tbl ForwardBE"}, 32'(ForwardBE), 32'(t.fb));
      chk({tag, " tbl stalls"},    32'(ast),       32'(t.st));
      chk({tag, " tbl FlushD"},    32'(FlushD),    32'(t.fd));
      chk({tag, " tbl CLR_E"},     32'(CLR_E),     32'(t.clr));
    end
    $display("%0t %s fa=%b fb=%b st=%b fd=%b clr=%b flt=%b sc=%0d fc=%0d", $time, tag,
             ForwardAE, ForwardBE, ast, FlushD, CLR_E, fault, stall_cnt, flush_cnt);
    @(posedge clk);
    if (v.rst) begin
      m_fault = 0; m_run = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (est != 0 && m_scnt < CMAX) m_scnt++;
      if (ecl && m_fcnt < CMAX) m_fcnt++;
      if (!m_fault) begin
        if (mw) begin
          m_run++;
          if (m_run > WT) m_fault = 1;
        end else begin
          m_run = 0;
        end
      end
    end
    #1;
  endtask

  task automatic go(input in_t v, input string tag);
    step(v, 1'b0, '0, tag);
  endtask

  task automatic do_reset();
    in_t v;
    v = idle();
    v.rst = 1'b1;
    go(v, "reset");
  endtask

  initial begin
    in_t v;
    m_fault = 0; m_run = 0; m_scnt = 0; m_fcnt = 0;

    // Fill the vector table (applied from RUN with no memory wait unless noted).
    v = idle(); v.rwm = 1; v.rdm = 5; v.rs1e = 5; v.rww = 1; v.rdw = 5;
    tbl[0] = '{v, 2'b10, 2'b00, 4'h0, 1'b0, 1'b0};
    v.rdm = 0;
    tbl[1] = '{v, 2'b01, 2'b00, 4'h0, 1'b0, 1'b0};
    v.rww = 0;
    tbl[2] = '{v, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0};
    v = idle(); v.rwm = 1; v.rdm = 9; v.rs2e = 9; v.rs1e = 3;
    tbl[3] = '{v, 2'b00, 2'b10, 4'h0, 1'b0, 1'b0};
    v = idle(); v.rwm = 1; v.rdm = 13; v.rww = 1; v.rdw = 12; v.rs2e = 12; v.rs1e = 13;
    tbl[4] = '{v, 2'b10, 2'b01, 4'h0, 1'b0, 1'b0};
    v = idle(); v.rww = 1; v.rdw = 0; v.rs1e = 0; v.rs2e = 0;
    tbl[5] = '{v, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0};
    v = idle(); v.rsrc = 2'b01; v.rde = 7; v.rs2d = 7;
    tbl[6] = '{v, 2'b00, 2'b00, 4'b1100, 1'b0, 1'b1};
    v = idle(); v.rsrc = 2'b01; v.rde = 0; v.rs1d = 0;
    tbl[7] = '{v, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0};
    v = idle(); v.rsrc = 2'b00; v.rde = 7; v.rs1d = 7;
    tbl[8] = '{v, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0};
    v = idle(); v.rsrc = 2'b01; v.rde = 7; v.rs1d = 7; v.pcsrc = 1;
    tbl[9] = '{v, 2'b00, 2'b00, 4'h0, 1'b1, 1'b1};
    v.req = 1; v.rdy = 0;
    tbl[10] = '{v, 2'b00, 2'b00, 4'hF, 1'b0, 1'b0};

    // Raw reset so DUT and model start from a known point.
    v = idle(); v.rst = 1;
    {rst, Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, RdM, RdW, RegWriteM, RegWriteW,
     dmem_req_M, dmem_ready} = v;
    @(posedge clk); @(posedge clk); #1;

    // Reset forces forwarding off and flushes, even with matching operands.
    v = idle(); v.rst = 1; v.rwm = 1; v.rdm = 5; v.rs1e = 5; v.rs2e = 5; v.pcsrc = 1;
    go(v, "reset_outputs");

    for (int k = 0; k < 11; k++) step(tbl[k].i, 1'b1, tbl[k], $sformatf("tbl%0d", k));
    v = idle(); v.req = 1; v.rdy = 1;
    go(v, "tbl_ready");

    // Single load-use bubble.
    do_reset();
    v = idle(); v.rsrc = 2'b01; v.rde = 7; v.rs2d = 7;
    go(v, "loaduse");
    go(idle(), "loaduse_after");
    chk("loaduse stall_cnt", 32'(stall_cnt), 32'd1);
    chk("loaduse flush_cnt", 32'(flush_cnt), 32'd1);

    // Three wait cycles then ready.
    do_reset();
    v = idle(); v.req = 1; v.rdy = 0;
    for (int k = 0; k < 3; k++) go(v, "memwait");
    v.rdy = 1;
    go(v, "memready");
    chk("memwait stall_cnt", 32'(stall_cnt), 32'd3);
    chk("memwait fault", 32'(fault), 32'd0);

    // Timeout into FAULT; stalls hold even when the request drops.
    do_reset();
    v = idle(); v.req = 1; v.rdy = 0;
    for (int k = 0; k < WT + 1; k++) go(v, "timeout_wait");
    chk("timeout fault", 32'(fault), 32'd1);
    v = idle(); v.pcsrc = 1;
    go(v, "fault_hold");
    chk("timeout stall_cnt", 32'(stall_cnt), 32'(WT + 2));
    do_reset();
    chk("post_fault fault", 32'(fault), 32'd0);
    chk("post_fault stall_cnt", 32'(stall_cnt), 32'd0);
    chk("post_fault flush_cnt", 32'(flush_cnt), 32'd0);

    // Reset in the middle of a wait returns to RUN without ready.
    v = idle(); v.req = 1; v.rdy = 0;
    go(v, "midwait"); go(v, "midwait");
    v.rst = 1;
    go(v, "midwait_rst");
    go(idle(), "midwait_after");
    chk("midwait stall_cnt", 32'(stall_cnt), 32'd0);

    // Counter saturation.
    do_reset();
    v = idle(); v.rsrc = 2'b01; v.rde = 3; v.rs1d = 3;
    for (int k = 0; k < 20; k++) go(v, "saturate");
    chk("saturate stall_cnt", 32'(stall_cnt), 32'(CMAX));
    chk("saturate flush_cnt", 32'(flush_cnt), 32'(CMAX));

    // Random traffic with small register numbers so hazards are frequent.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      v = idle();
      v.rst   = ($urandom_range(0, 39) == 0);
      v.rs1d  = 5'($urandom_range(0, 7)); v.rs2d = 5'($urandom_range(0, 7));
      v.rs1e  = 5'($urandom_range(0, 7)); v.rs2e = 5'($urandom_range(0, 7));
      v.rde   = 5'($urandom_range(0, 7)); v.rdm  = 5'($urandom_range(0, 7));
      v.rdw   = 5'($urandom_range(0, 7));
      v.rsrc  = 2'($urandom_range(0, 3));
      v.pcsrc = ($urandom_range(0, 5) == 0);
      v.rwm   = 1'($urandom_range(0, 1)); v.rww = 1'($urandom_range(0, 1));
      v.req   = ($urandom_range(0, 2) == 0);
      v.rdy   = 1'($urandom_range(0, 1));
      go(v, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
